// File: rtl/bcd_countdown_timer_p.sv
// bcd_countdown_timer_p
// Parametrised BCD countdown / count-up timer (MM:SS, optionally HH:MM:SS).
// Digits are entered one at a time through `in` while `load` is high, and
// the entered value is normalised when load is released. Counting then
// advances once per prescaled tick, either down to zero or up to the preset.
// All count arithmetic is done per 4-bit BCD digit.

module bcd_countdown_timer_p #(
    parameter int TICK_DIV  = 1,
    parameter int HAS_HOURS = 0,
    parameter int NDIG      = 4 + 2 * HAS_HOURS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enablen,
    input  logic              load,
    input  logic [3:0]        in,
    input  logic              mode,
    input  logic              auto_reload,
    output logic [4*NDIG-1:0] digits,
    output logic              running,
    output logic              finished
);

    localparam int DW = 4 * NDIG;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    // Largest legal value of digit position idx: tens of seconds and tens
    // of minutes stop at 5, every other position (units, hours) at 9.
    function automatic logic [3:0] digit_max(input int idx);
        logic [3:0] lim;
        case (idx)
            1, 3:    lim = 4'd5;
            default: lim = 4'd9;
        endcase
        return lim;
    endfunction

    // Entered digits above 9 are stored as 9.
    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        logic [3:0] r;
        if (d > 4'd9) begin
            r = 4'd9;
        end else begin
            r = d;
        end
        return r;
    endfunction

    // Clamp every digit to its positional maximum (tens of sec/min to 5).
    function automatic logic [DW-1:0] normalise(input logic [DW-1:0] v);
        logic [DW-1:0] r;
        logic [3:0]    d;
        r = v;
        for (int i = 0; i < NDIG; i++) begin
            d = v[4*i +: 4];
            if (d > digit_max(i)) begin
                r[4*i +: 4] = digit_max(i);
            end else begin
                r[4*i +: 4] = d;
            end
        end
        return r;
    endfunction

    // Shift a new digit into position 0; the top digit falls off.
    function automatic logic [DW-1:0] shift_in(input logic [DW-1:0] v,
                                               input logic [3:0]    d);
        return {v[DW-5:0], clamp_digit(d)};
    endfunction

    // BCD decrement with borrow rippling through positional moduli.
    function automatic logic [DW-1:0] bcd_dec(input logic [DW-1:0] v);
        logic [DW-1:0] r;
        logic [3:0]    d;
        logic          borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            d = v[4*i +: 4];
            if (!borrow) begin
                r[4*i +: 4] = d;
            end else if (d == 4'd0) begin
                r[4*i +: 4] = digit_max(i);
                borrow      = 1'b1;
            end else begin
                r[4*i +: 4] = d - 4'd1;
                borrow      = 1'b0;
            end
        end
        return r;
    endfunction

    // BCD increment with carry; with hours present the top saturates at 99.
    function automatic logic [DW-1:0] bcd_inc(input logic [DW-1:0] v);
        logic [DW-1:0] r;
        logic [3:0]    d;
        logic          carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            d = v[4*i +: 4];
            if (!carry) begin
                r[4*i +: 4] = d;
            end else if (d >= digit_max(i)) begin
                r[4*i +: 4] = 4'd0;
                carry       = 1'b1;
            end else begin
                r[4*i +: 4] = d + 4'd1;
                carry       = 1'b0;
            end
        end
        if (carry && (HAS_HOURS != 0)) begin
            r = v;
        end else begin
            r = r;
        end
        return r;
    endfunction

    logic [DW-1:0] preset_r, preset_s;
    logic [DW-1:0] digits_r, digits_s;
    logic [PW-1:0] presc_r, presc_s;
    logic          finished_r, finished_s;
    logic          running_r, running_s;
    logic          mode_r, mode_s;
    logic          load_d_r, load_d_s;
    logic          tick_s;
    logic [DW-1:0] step_s;
    logic [DW-1:0] norm_s;

    // Next-state logic: load > release > tick, enablen freezes the rest.
    always_comb begin
        preset_s   = preset_r;
        digits_s   = digits_r;
        presc_s    = presc_r;
        finished_s = finished_r;
        mode_s     = mode_r;
        load_d_s   = load_d_r;
        norm_s     = normalise(preset_r);
        step_s     = mode_r ? bcd_inc(digits_r) : bcd_dec(digits_r);
        tick_s     = (presc_r == PRESC_LAST) && (!finished_r || auto_reload);

        if (load) begin
            preset_s   = shift_in(preset_r, in);
            digits_s   = shift_in(preset_r, in);
            finished_s = 1'b0;
            presc_s    = {PW{1'b0}};
            load_d_s   = 1'b1;
        end else if (load_d_r) begin
            // First cycle after entry: clean up the preset and start.
            preset_s   = norm_s;
            mode_s     = mode;
            digits_s   = mode ? {DW{1'b0}} : norm_s;
            finished_s = (norm_s == {DW{1'b0}});
            presc_s    = {PW{1'b0}};
            load_d_s   = 1'b0;
        end else if (!enablen) begin
            if (presc_r == PRESC_LAST) begin
                presc_s = {PW{1'b0}};
            end else begin
                presc_s = presc_r + PW'(1);
            end
            if (tick_s && finished_r) begin
                // Auto-reload one tick after the terminal value.
                digits_s   = mode_r ? {DW{1'b0}} : preset_r;
                finished_s = 1'b0;
            end else if (tick_s) begin
                digits_s   = step_s;
                finished_s = mode_r ? (step_s == preset_r)
                                    : (step_s == {DW{1'b0}});
            end else begin
                digits_s   = digits_r;
                finished_s = finished_r;
            end
        end else begin
            presc_s  = presc_r;
            digits_s = digits_r;
        end

        // Uses the upcoming finished value so a zero preset never
        // shows a spurious running pulse on the release edge.
        running_s = ~load & ~enablen & ~(finished_s & ~auto_reload);
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            preset_r   <= {DW{1'b0}};
            digits_r   <= {DW{1'b0}};
            presc_r    <= {PW{1'b0}};
            finished_r <= 1'b0;
            running_r  <= 1'b0;
            mode_r     <= 1'b0;
            load_d_r   <= 1'b0;
        end else begin
            preset_r   <= preset_s;
            digits_r   <= digits_s;
            presc_r    <= presc_s;
            finished_r <= finished_s;
            running_r  <= running_s;
            mode_r     <= mode_s;
            load_d_r   <= load_d_s;
        end
    end

    assign digits   = digits_r;
    assign running  = running_r;
    assign finished = finished_r;

endmodule

// File: tb/tb_bcd_countdown_timer_p.sv
// Bench for bcd_countdown_timer_p. Two instances share stimulus:
// inst 0 is MM:SS with TICK_DIV=1, inst 1 is HH:MM:SS with TICK_DIV=3.
// The reference model keeps the count as a plain number of seconds and
// only converts to BCD for comparison.

module tb_bcd_countdown_timer_p;

    logic        clk;
    logic        rst;
    logic        enablen;
    logic        load;
    logic [3:0]  din;
    logic        mode;
    logic        auto_reload;
    logic [15:0] dig0;
    logic [23:0] dig1;
    logic        run0, run1, fin0, fin1;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // Model state per instance
    int td[2] = '{1, 3};
    int nd[2] = '{4, 6};
    int mx[2] = '{3599, 359999};
    int pd[2][6];
    int secs[2], tgt[2], presc[2];
    bit md[2], fin_m[2], ld_m[2], run_m[2], shown_pre[2];

    bcd_countdown_timer_p #(.TICK_DIV(1), .HAS_HOURS(0)) u_mmss (
        .clk(clk), .rst(rst), .enablen(enablen), .load(load), .in(din),
        .mode(mode), .auto_reload(auto_reload),
        .digits(dig0), .running(run0), .finished(fin0)
    );

    bcd_countdown_timer_p #(.TICK_DIV(3), .HAS_HOURS(1)) u_hhmmss (
        .clk(clk), .rst(rst), .enablen(enablen), .load(load), .in(din),
        .mode(mode), .auto_reload(auto_reload),
        .digits(dig1), .running(run1), .finished(fin1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] to_bcd(input int s);
        int h, m, sc;
        h  = s / 3600;
        m  = (s / 60) % 60;
        sc = s % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
                4'(sc / 10), 4'(sc % 10)};
    endfunction

    function automatic logic [23:0] exp_digits(input int k);
        logic [23:0] r;
        r = 24'h0;
        if (shown_pre[k]) begin
            for (int i = 0; i < nd[k]; i++) r[4*i +: 4] = 4'(pd[k][i]);
        end else begin
            r = to_bcd(secs[k]);
        end
        return r;
    endfunction

    task automatic model_step(input int k);
        bit tick;
        if (!rst) begin
            for (int i = 0; i < 6; i++) pd[k][i] = 0;
            secs[k] = 0; tgt[k] = 0; presc[k] = 0;
            md[k] = 0; fin_m[k] = 0; ld_m[k] = 0; shown_pre[k] = 0;
        end else if (load) begin
            for (int i = nd[k] - 1; i > 0; i--) pd[k][i] = pd[k][i-1];
            pd[k][0] = (din > 4'd9) ? 9 : int'(din);
            shown_pre[k] = 1; fin_m[k] = 0; presc[k] = 0; ld_m[k] = 1;
        end else if (ld_m[k]) begin
            if (pd[k][1] > 5) pd[k][1] = 5;
            if (pd[k][3] > 5) pd[k][3] = 5;
            tgt[k] = pd[k][0] + 10 * pd[k][1] + 60 * (pd[k][2] + 10 * pd[k][3])
                   + 3600 * (pd[k][4] + 10 * pd[k][5]);
            md[k] = mode;
            secs[k] = mode ? 0 : tgt[k];
            fin_m[k] = (tgt[k] == 0);
            ld_m[k] = 0; presc[k] = 0; shown_pre[k] = 0;
        end else if (!enablen) begin
            tick = (presc[k] == td[k] - 1) && (!fin_m[k] || auto_reload);
            presc[k] = (presc[k] == td[k] - 1) ? 0 : presc[k] + 1;
            if (tick && fin_m[k]) begin
                secs[k] = md[k] ? 0 : tgt[k];
                fin_m[k] = 0;
            end else if (tick) begin
                if (md[k]) secs[k] = (secs[k] == mx[k]) ? ((k == 0) ? 0 : mx[k]) : secs[k] + 1;
                else       secs[k] = (secs[k] == 0) ? mx[k] : secs[k] - 1;
                fin_m[k] = md[k] ? (secs[k] == tgt[k]) : (secs[k] == 0);
            end
        end
        run_m[k] = rst && !load && !enablen && !(fin_m[k] && !auto_reload);
    endtask

    // Advance the reference model on every active edge.
    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    // Compare every output of both instances against the model each cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check_eq("dig0", {16'h0, dig0}, {8'h0, exp_digits(0)});
            check_eq("dig1", {8'h0, dig1}, {8'h0, exp_digits(1)});
            check_eq("fin0", {31'h0, fin0}, {31'h0, fin_m[0]});
            check_eq("fin1", {31'h0, fin1}, {31'h0, fin_m[1]});
            check_eq("run0", {31'h0, run0}, {31'h0, run_m[0]});
            check_eq("run1", {31'h0, run1}, {31'h0, run_m[1]});
        end
    end

    // Enter n digits, first entered = most significant nibble of seq.
    task automatic load_digits(input logic [23:0] seq, input int n);
        load = 1'b1;
        for (int j = n - 1; j >= 0; j--) begin
            din = seq[4*j +: 4];
            @(negedge clk);
        end
        load = 1'b0;
        din  = 4'h0;
    endtask

    initial begin : stim
        int r;
        rst = 1'b0; enablen = 1'b1; load = 1'b0; din = 4'h0;
        mode = 1'b0; auto_reload = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        check_eq("rst_dig0", {16'h0, dig0}, 32'h0);
        check_eq("rst_dig1", {8'h0, dig1}, 32'h0);
        check_eq("rst_fin", {30'h0, fin0, fin1}, 32'h0);
        check_eq("rst_run", {30'h0, run0, run1}, 32'h0);
        rst = 1'b1;

        // 01:05 count down to zero
        enablen = 1'b0;
        load_digits(24'h0105, 4);
        @(negedge clk);
        check_eq("t1_rel", {16'h0, dig0}, 32'h0105);
        @(negedge clk);
        check_eq("t1_tick1", {16'h0, dig0}, 32'h0104);
        repeat (4) @(negedge clk);
        check_eq("t1_tick5", {16'h0, dig0}, 32'h0100);
        @(negedge clk);
        check_eq("t1_tick6", {16'h0, dig0}, 32'h0059);
        repeat (58) @(negedge clk);
        check_eq("t1_tick64", {15'h0, fin0, dig0}, 32'h0001);
        @(negedge clk);
        check_eq("t1_tick65", {15'h0, fin0, dig0}, 32'h10000);
        repeat (5) @(negedge clk);
        check_eq("t1_hold", {15'h0, fin0, dig0}, 32'h10000);

        // Entry clamp
        load_digits(24'h798C, 4);
        @(negedge clk);
        check_eq("t2_clamp", {16'h0, dig0}, 32'h5959);

        // Count up to 00:00:02 with auto reload, inst 1 ticks every 3 cycles
        mode = 1'b1; auto_reload = 1'b1;
        load_digits(24'h000002, 6);
        @(negedge clk);
        check_eq("t3_e0", {7'h0, fin1, dig1}, 32'h0);
        repeat (3) @(negedge clk);
        check_eq("t3_e3", {7'h0, fin1, dig1}, 32'h1);
        repeat (2) @(negedge clk);
        check_eq("t3_e5", {7'h0, fin1, dig1}, 32'h1);
        @(negedge clk);
        check_eq("t3_e6", {7'h0, fin1, dig1}, 32'h1000002);
        @(negedge clk);
        check_eq("t3_e7", {31'h0, fin1}, 32'h1);
        @(negedge clk);
        check_eq("t3_e8", {31'h0, fin1}, 32'h1);
        @(negedge clk);
        check_eq("t3_e9", {7'h0, fin1, dig1}, 32'h0);
        repeat (3) @(negedge clk);
        check_eq("t3_e12", {7'h0, fin1, dig1}, 32'h1);

        // 01:00:00 down, then freeze, load pulse and reset mid-count
        mode = 1'b0; auto_reload = 1'b0;
        load_digits(24'h010000, 6);
        @(negedge clk);
        check_eq("t4_rel", {8'h0, dig1}, 32'h010000);
        repeat (3) @(negedge clk);
        check_eq("t4_tick1", {8'h0, dig1}, 32'h005959);
        @(negedge clk);
        enablen = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("frz_dig", {8'h0, dig1}, 32'h005959);
        check_eq("frz_run", {30'h0, run0, run1}, 32'h0);
        enablen = 1'b0;
        @(negedge clk);
        check_eq("frz_presc1", {8'h0, dig1}, 32'h005959);
        @(negedge clk);
        check_eq("frz_presc2", {8'h0, dig1}, 32'h005958);
        load = 1'b1; din = 4'h3;
        @(negedge clk);
        check_eq("ldpulse", {7'h0, fin1, dig1}, 32'h100003);
        load = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("mid_rst", {5'h0, fin1, run1, fin0, run0, dig1}, 32'h0);
        rst = 1'b1;

        // Zero preset: finished on release, running stays low
        load_digits(24'h000000, 6);
        @(negedge clk);
        check_eq("zero_fin", {30'h0, fin0, fin1}, 32'h3);
        check_eq("zero_run", {30'h0, run0, run1}, 32'h0);
        @(negedge clk);
        check_eq("zero_run2", {30'h0, run0, run1}, 32'h0);

        // Randomised phase, checked cycle by cycle against the model
        for (int it = 0; it < 40; it++) begin
            mode        = 1'($urandom_range(0, 1));
            auto_reload = ($urandom_range(0, 3) == 0);
            enablen     = 1'b0;
            load = 1'b1;
            for (int j = 0; j < int'($urandom_range(1, 6)); j++) begin
                din = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                  : 4'($urandom_range(0, 2));
                @(negedge clk);
            end
            load = 1'b0;
            for (int c = 0; c < int'($urandom_range(20, 400)); c++) begin
                r = int'($urandom_range(0, 99));
                enablen = (r < 8);
                rst     = (r != 99);
                load    = (r == 97);
                din     = 4'($urandom_range(0, 15));
                if (r == 96) auto_reload = ~auto_reload;
                @(negedge clk);
            end
            rst = 1'b1; load = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bcd_countdown_timer_p.md
Name: bcd_countdown_timer_p

Overview:
Parametrised successor to the fixed four-digit MM:SS timer. Adds an optional hours field, a clock prescaler, a count-up (stopwatch-to-target) mode, auto-reload, and a running flag. Sits between the keypad/digit-entry logic and the seven-segment display driver. All digits are BCD.

Parameters:
TICK_DIV, 1, clock cycles per one-second tick (1 = one tick per clk, sim default); legal range 1..2^16
HAS_HOURS, 0, 1 adds two hour digits HH (00-99) above MM:SS; 0 = MM:SS only
NDIG, 4+2*HAS_HOURS, derived digit count, not to be overridden

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset; one clock; reset is synchronous and active-low
enablen  in  1  active-low count enable; high freezes count and prescaler
load  in  1  digit-entry strobe; high = shift `in` into digit 0 each cycle
in  in  4  BCD digit being entered
mode  in  1  0 = count down from preset, 1 = count up from 0 to preset; sampled at load release
auto_reload  in  1  1 = restart automatically on finish
digits  out  4*NDIG  count value; [3:0] = second units, [7:4] = second tens, [11:8] = minute units, [15:12] = minute tens, [23:16] = hours (if HAS_HOURS)
running  out  1  high while counting is active (not finished, not loading, enablen low)
finished  out  1  terminal-count indicator

Behaviour:
- Reset (rst=0 at edge): digits=0, preset=0, prescaler=0, finished=0, running=0, latched mode=0. rst has priority over everything.
- Load phase, each edge with load=1: preset shifts left one digit; in goes to digit 0; the top digit is discarded. in>9 is stored as 9. digits mirror preset. finished=0, prescaler=0.
- Load release, first edge with load=0 after load=1:
  - Normalise preset: second tens >5 -> 5; minute tens >5 -> 5.
  - Latch mode.
  - digits = preset (mode 0) or 0 (mode 1).
  - If preset==0, finished=1 on this edge.
- Tick: load=0, enablen=0, finished=0 (or auto_reload=1), and prescaler==TICK_DIV-1. Prescaler otherwise increments, wrapping to 0 on tick.
  - If enablen=1, the prescaler holds.
- Down count on tick: BCD decrement with borrow. sec 00 -> 59 with borrow into minutes; min 00 -> 59 with borrow into hours.
- Up count on tick: BCD increment. sec 59 -> 00 with carry; min 59 -> 00 with carry; hours 99 saturate (unreachable, since target <= preset).
- Terminal condition: digits==0 (mode 0) or digits==preset (mode 1). finished goes high on the same edge the terminal value is written.
- auto_reload=0: counting stops; finished holds 1 until the next load or reset.
- auto_reload=1: on the tick after terminal, digits reload (preset or 0). finished goes low on that edge. finished is therefore high for exactly TICK_DIV cycles.
- Toggling auto_reload while finished=1 with counting stopped:
  - Raising it to 1 resumes counting at the next tick.
  - Lowering it to 0 while finished=1 freezes the count.
- Priority order: rst > load > release > tick.
  - load asserted mid-count aborts counting immediately; digit entry starts from the current preset.
  - enablen has no effect on load.
- running = rst & ~load & ~enablen & ~(finished & ~auto_reload), registered (one-cycle lag accepted).
- Count width: all arithmetic is per-digit 4-bit BCD. No binary intermediate register wider than the prescaler (ceil(log2(TICK_DIV)) bits, minimum 1).

Test Plan:
- HAS_HOURS=0, TICK_DIV=1, mode 0: load digits 0,1,0,5 (01:05); enablen=0.
  - Required: digits 0x0104 after 1 tick, 0x0100 after 5, 0x0059 after 6.
  - Required: finished=1 exactly at tick 65, and count holds 0x0000.
- Entry clamp: load 7,9,8,C.
  - Required: preset normalised to 0x5959 at release (digit C -> 9, tens 7 -> 5, 8 -> 5).
- Mode 1, auto_reload=1, TICK_DIV=3, preset 00:02.
  - Required sequence at 3-cycle spacing: 00, 01, 02.
  - Required: finished high for exactly 3 cycles, then digits=0 and counting continues.
- HAS_HOURS=1, preset 01:00:00, mode 0.
  - Required: first tick -> 00:59:59 (digits 0x005959).
- Interrupts:
  - enablen=1 for 10 cycles mid-count: digits and prescaler frozen.
  - load pulse mid-count: finished=0 and the new digit is shifted in.
  - rst=0 mid-count: all outputs 0 at the next edge.
- Preset 00:00 released: finished=1 on the release edge, running stays 0.
